// File: rtl/jlc3_run_ctrl.sv
// jlc3_run_ctrl: run/reset sequencer for the jlc3 SoC.
// Generates a timed power-on core reset, then gates the SoC enable under
// run / halt / single-step control, with a synchronous soft-reset request.
// Optional watchdog: define JLC3_RUN_CTRL_WDT_EN to enable it.
module jlc3_run_ctrl #(
  parameter int unsigned POR_CYCLES  = 100,
  parameter int unsigned STEP_CYCLES = 1,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WDT_CYCLES  = 1000,
  parameter int unsigned WDT_W       = 16
) (
  input  logic       clk_i_w,
  input  logic       rst_i_w,
  input  logic       run_req_i_w,
  input  logic       step_req_i_w,
  input  logic       soft_rst_req_i_w,
  input  logic       kick_i_w,
  output logic       core_rst_o_w,
  output logic       core_en_o_w,
  output logic       busy_o_w,
  output logic [1:0] state_o_w,
  output logic       wdt_o_w
);

  typedef enum logic [1:0] {
    ST_POR  = 2'd0,
    ST_HALT = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_prev_q;
  logic             step_edge_c;
  logic             core_rst_d, core_en_d, busy_d;
  logic             wdt_timeout_c;

  assign step_edge_c = step_req_i_w & ~step_prev_q;

`ifdef JLC3_RUN_CTRL_WDT_EN
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             wdt_q, wdt_d;

  // Timeout fires in RUN when the count reaches its limit; a kick wins.
  assign wdt_timeout_c = (state_q == ST_RUN) && !kick_i_w && (wdt_cnt_q == WDT_LAST);

  // Watchdog counts only while staying in RUN; kick or leaving RUN clears it.
  always_comb begin
    wdt_cnt_d = '0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN) && !kick_i_w)
      wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
    wdt_d = wdt_q | wdt_timeout_c;
  end

  // Watchdog registers; the expired flag is cleared only by rst_i_w.
  always_ff @(posedge clk_i_w or posedge rst_i_w) begin
    if (rst_i_w) begin
      wdt_cnt_q <= '0;
      wdt_q     <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      wdt_q     <= wdt_d;
    end
  end

  assign wdt_o_w = wdt_q;
`else
  logic unused_wdt_c;

  // Watchdog absent: kick and its parameters have no effect.
  assign unused_wdt_c  = kick_i_w | (WDT_CYCLES == 0) | (WDT_W == 0);
  assign wdt_timeout_c = 1'b0;
  assign wdt_o_w       = 1'b0;
`endif

  // Next-state and next-output logic; soft reset and watchdog timeout dominate.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (soft_rst_req_i_w || wdt_timeout_c) begin
      state_d = ST_POR;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_POR: begin
          if (cnt_q == POR_LAST) begin
            cnt_d   = '0;
            state_d = run_req_i_w ? ST_RUN : ST_HALT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HALT: begin
          if (run_req_i_w) begin
            state_d = ST_RUN;
          end else if (step_edge_c) begin
            state_d = ST_STEP;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          if (!run_req_i_w) state_d = ST_HALT;
        end
        ST_STEP: begin
          if (cnt_q == STEP_LAST) begin
            state_d = ST_HALT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_POR;
          cnt_d   = '0;
        end
      endcase
    end
    core_rst_d = (state_d == ST_POR);
    core_en_d  = (state_d == ST_RUN) || (state_d == ST_STEP);
    busy_d     = (state_d == ST_STEP);
  end

  // State, counter, edge detector and registered outputs.
  always_ff @(posedge clk_i_w or posedge rst_i_w) begin
    if (rst_i_w) begin
      state_q      <= ST_POR;
      cnt_q        <= '0;
      step_prev_q  <= 1'b0;
      core_rst_o_w <= 1'b1;
      core_en_o_w  <= 1'b0;
      busy_o_w     <= 1'b0;
      state_o_w    <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_prev_q  <= step_req_i_w;
      core_rst_o_w <= core_rst_d;
      core_en_o_w  <= core_en_d;
      busy_o_w     <= busy_d;
      state_o_w    <= 2'(state_d);
    end
  end

endmodule

// File: tb/tb_jlc3_run_ctrl.sv
// Directed bench for jlc3_run_ctrl: POR timing, step, run/step priority,
// soft reset, async reset and watchdog (behaviour depends on JLC3_RUN_CTRL_WDT_EN).
module tb_jlc3_run_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_req = 1'b0;
  logic       step_req = 1'b0;
  logic       soft_rst = 1'b0;
  logic       kick = 1'b0;
  logic       core_rst, core_en, busy, wdt;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  jlc3_run_ctrl #(
    .POR_CYCLES (100),
    .STEP_CYCLES(3),
    .CNT_W      (8),
    .WDT_CYCLES (10),
    .WDT_W      (16)
  ) dut (
    .clk_i_w         (clk),
    .rst_i_w         (rst),
    .run_req_i_w     (run_req),
    .step_req_i_w    (step_req),
    .soft_rst_req_i_w(soft_rst),
    .kick_i_w        (kick),
    .core_rst_o_w    (core_rst),
    .core_en_o_w     (core_en),
    .busy_o_w        (busy),
    .state_o_w       (state),
    .wdt_o_w         (wdt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int         hi;
    logic [4:0] en_v, busy_v;
    int         bad;

    // Reset state
    run_req = 1'b1;
    repeat (3) tick();
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_en", core_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state, 0);
    chk("rst_wdt", wdt, 0);

    // 1: POR holds core reset for exactly 100 edges, then RUN
    rst = 1'b0;
    hi = 0;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (core_rst === 1'b1 && core_en === 1'b0 && state === 2'd0) hi++;
    end
    chk("por_hold_edges", hi, 99);
    tick();
    chk("por_end_core_rst", core_rst, 0);
    chk("por_end_core_en", core_en, 1);
    chk("por_end_state", state, 2);

    // 2: halt, then hold step high for 5 cycles -> one 3-cycle step
    run_req = 1'b0;
    tick();
    chk("halt_state", state, 1);
    chk("halt_core_en", core_en, 0);
    step_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      en_v[i]   = core_en;
      busy_v[i] = busy;
      if (i == 0) chk("step_state", state, 3);
    end
    chk("step_en_pattern", en_v, 5'b00111);
    chk("step_busy_pattern", busy_v, 5'b00111);
    chk("step_back_halt", state, 1);
    step_req = 1'b0;
    tick();
    chk("step_no_repeat", state, 1);

    // 3: run and step edge together -> RUN wins, no step
    run_req  = 1'b1;
    step_req = 1'b1;
    tick();
    chk("prio_state", state, 2);
    chk("prio_busy", busy, 0);
    tick();
    chk("prio_busy_hold", busy, 0);
    run_req  = 1'b0;
    step_req = 1'b0;
    chk("prio_en_before", core_en, 1);
    tick();
    chk("prio_halt_en", core_en, 0);
    chk("prio_halt_state", state, 1);

    // 4: soft reset one cycle into a step
    step_req = 1'b1;
    tick();
    chk("soft_step_entry", state, 3);
    step_req = 1'b0;
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("soft_core_rst", core_rst, 1);
    chk("soft_core_en", core_en, 0);
    chk("soft_busy", busy, 0);
    chk("soft_state", state, 0);
    hi = 0;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (core_rst === 1'b1) hi++;
    end
    chk("soft_por_edges", hi, 99);
    tick();
    chk("soft_por_end_rst", core_rst, 0);
    chk("soft_por_end_state", state, 1);

    // 5: asynchronous reset between edges while in RUN
    run_req = 1'b1;
    tick();
    chk("async_pre_state", state, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_core_rst", core_rst, 1);
    chk("async_core_en", core_en, 0);
    chk("async_state", state, 0);
    tick();
    rst = 1'b0;

    // 6: watchdog with kicks every 8 cycles, then timeout
    repeat (100) tick();
    chk("wdt_run_state", state, 2);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      kick = 1'b1;
      tick();
      kick = 1'b0;
      if (state !== 2'd2) bad++;
      repeat (7) begin
        tick();
        if (state !== 2'd2) bad++;
      end
    end
    chk("wdt_kicked_no_reset", bad, 0);
    kick = 1'b1;
    tick();
    kick = 1'b0;
    repeat (9) tick();
    chk("wdt_before_timeout", state, 2);
    tick();
`ifdef JLC3_RUN_CTRL_WDT_EN
    chk("wdt_timeout_state", state, 0);
    chk("wdt_timeout_rst", core_rst, 1);
    chk("wdt_flag", wdt, 1);
`else
    chk("wdt_off_state", state, 2);
    chk("wdt_off_rst", core_rst, 0);
    chk("wdt_off_flag", wdt, 0);
`endif
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("wdt_soft_state", state, 0);
`ifdef JLC3_RUN_CTRL_WDT_EN
    chk("wdt_flag_sticky", wdt, 1);
`else
    chk("wdt_off_flag_soft", wdt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
